// File: rtl/mips_pkg.sv
`default_nettype none
// ============================================================================
// Module   : mips_pkg
// Purpose  : Shared MIPS decode constants and the decoded-entry record that
//            travels from the ID stage into the control signal generator.
// Revision : 1.0 - initial release
// ============================================================================
package mips_pkg;

  // Widest pass-through PC an entry can carry; PC_W of the stage must not exceed it
  localparam int PC_MAX_W = 32;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_ANDI  = 6'b001100;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_JAL   = 6'b000011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] FUNCT_JR = 6'b001000;

  // One-hot instruction class flags, in the order the control generator expects
  typedef struct packed {
    logic rt_type;
    logic addi;
    logic andi;
    logic lw;
    logic sw;
    logic j;
    logic jal;
    logic jr;
    logic beq;
    logic bne;
  } dec_flags_t;

  typedef struct packed {
    dec_flags_t            flags;
    logic [4:0]            rs;
    logic [4:0]            rt;
    logic [4:0]            rd;
    logic [15:0]           imm;
    logic [25:0]           target;
    logic [PC_MAX_W-1:0]   pc;
    logic                  illegal;
  } dec_entry_t;

endpackage
`default_nettype wire

// File: rtl/opcode_decode.sv
`default_nettype none
// ============================================================================
// Module   : opcode_decode
// Purpose  : Purely combinational instruction word -> decoded entry. The pc
//            field is left zero; the stage fills it in.
// Revision : 1.0 - initial release
// ============================================================================
module opcode_decode
  import mips_pkg::*;
(
  input  logic [31:0] i_instr,
  output dec_entry_t  o_entry
);

  logic [5:0] w_op;
  logic [5:0] w_funct;

  assign w_op    = i_instr[31:26];
  assign w_funct = i_instr[5:0];

  // Field extraction plus one-hot class selection; unknown opcodes flag illegal
  always_comb begin
    o_entry        = '0;
    o_entry.rs     = i_instr[25:21];
    o_entry.rt     = i_instr[20:16];
    o_entry.rd     = i_instr[15:11];
    o_entry.imm    = i_instr[15:0];
    o_entry.target = i_instr[25:0];
    case (w_op)
      OP_RTYPE: begin
        if (w_funct == FUNCT_JR) o_entry.flags.jr      = 1'b1;
        else                     o_entry.flags.rt_type = 1'b1;
      end
      OP_ADDI: o_entry.flags.addi = 1'b1;
      OP_ANDI: o_entry.flags.andi = 1'b1;
      OP_LW:   o_entry.flags.lw   = 1'b1;
      OP_SW:   o_entry.flags.sw   = 1'b1;
      OP_J:    o_entry.flags.j    = 1'b1;
      OP_JAL:  o_entry.flags.jal  = 1'b1;
      OP_BEQ:  o_entry.flags.beq  = 1'b1;
      OP_BNE:  o_entry.flags.bne  = 1'b1;
      default: o_entry.illegal    = 1'b1;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/instr_decode_stage.sv
`default_nettype none
// ============================================================================
// Module   : instr_decode_stage
// Purpose  : Registered ID-stage decoder with valid/ready on both sides and a
//            2-entry (main M + skid S) buffer. in_ready depends only on held
//            state and flush, never on out_ready.
// Config   : ILLEGAL_TRAP_EN - pass illegal entries downstream and count
//            their takes on illegal_cnt; otherwise they are dropped at accept.
// Revision : 1.0 - initial release
// ============================================================================
module instr_decode_stage
  import mips_pkg::*;
#(
  parameter int PC_W = 32   // must not exceed PC_MAX_W
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     instr,
  input  logic [PC_W-1:0] in_pc,
  output logic            out_valid,
  input  logic            out_ready,
  output logic            rt_type,
  output logic            addi,
  output logic            andi,
  output logic            lw,
  output logic            sw,
  output logic            j,
  output logic            jal,
  output logic            jr,
  output logic            beq,
  output logic            bne,
  output logic [4:0]      rs,
  output logic [4:0]      rt,
  output logic [4:0]      rd,
  output logic [15:0]     imm,
  output logic [25:0]     target,
  output logic [PC_W-1:0] out_pc,
  output logic            illegal
`ifdef ILLEGAL_TRAP_EN
  ,
  output logic [7:0]      illegal_cnt
`endif
);

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_FULL  = 2'd2
  } state_t;

  state_t     r_state;
  dec_entry_t r_m;
  dec_entry_t r_s;
  dec_entry_t w_dec;
  dec_entry_t w_in_entry;
  logic       w_accept;
  logic       w_take;
  logic       w_store;

  opcode_decode u_opcode_decode (
    .i_instr (instr),
    .o_entry (w_dec)
  );

  // Attach the incoming pc to the decoded fields
  always_comb begin
    w_in_entry                = w_dec;
    w_in_entry.pc             = '0;
    w_in_entry.pc[PC_W-1:0]   = in_pc;
  end

  assign in_ready  = (r_state != ST_FULL) && !flush;
  assign out_valid = (r_state != ST_EMPTY);
  assign w_accept  = in_valid && in_ready;
  assign w_take    = out_valid && out_ready;

`ifdef ILLEGAL_TRAP_EN
  assign w_store = w_accept;
`else
  // Illegal words are consumed from fetch but never held
  assign w_store = w_accept && !w_dec.illegal;
`endif

  // Occupancy FSM; M/S are zeroed whenever they stop holding a live entry so
  // every output reads 0 while out_valid is low
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_EMPTY;
      r_m     <= '0;
      r_s     <= '0;
    end else if (flush) begin
      r_state <= ST_EMPTY;
      r_m     <= '0;
      r_s     <= '0;
    end else begin
      case (r_state)
        ST_EMPTY: begin
          if (w_store) begin
            r_m     <= w_in_entry;
            r_state <= ST_ONE;
          end
        end
        ST_ONE: begin
          case ({w_store, w_take})
            2'b11: r_m <= w_in_entry;
            2'b10: begin
              r_s     <= w_in_entry;
              r_state <= ST_FULL;
            end
            2'b01: begin
              r_m     <= '0;
              r_state <= ST_EMPTY;
            end
            default: ;
          endcase
        end
        ST_FULL: begin
          if (w_take) begin
            r_m     <= r_s;
            r_s     <= '0;
            r_state <= ST_ONE;
          end
        end
        default: r_state <= ST_EMPTY;
      endcase
    end
  end

`ifdef ILLEGAL_TRAP_EN
  logic [7:0] r_illegal_cnt;

  // Saturating count of illegal entries handed to the consumer (flush-cycle takes included)
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_illegal_cnt <= '0;
    end else if (w_take && r_m.illegal && (r_illegal_cnt != 8'hFF)) begin
      r_illegal_cnt <= r_illegal_cnt + 8'd1;
    end
  end

  assign illegal_cnt = r_illegal_cnt;
`endif

  assign rt_type = r_m.flags.rt_type;
  assign addi    = r_m.flags.addi;
  assign andi    = r_m.flags.andi;
  assign lw      = r_m.flags.lw;
  assign sw      = r_m.flags.sw;
  assign j       = r_m.flags.j;
  assign jal     = r_m.flags.jal;
  assign jr      = r_m.flags.jr;
  assign beq     = r_m.flags.beq;
  assign bne     = r_m.flags.bne;
  assign rs      = r_m.rs;
  assign rt      = r_m.rt;
  assign rd      = r_m.rd;
  assign imm     = r_m.imm;
  assign target  = r_m.target;
  assign out_pc  = r_m.pc[PC_W-1:0];
  // Without the trap, illegal entries are never stored so this stays 0
  assign illegal = r_m.illegal;

endmodule
`default_nettype wire

// File: tb/tb_instr_decode_stage.sv
`default_nettype none
// ============================================================================
// Module   : tb_instr_decode_stage
// Purpose  : Self-checking bench for instr_decode_stage: directed scenarios
//            followed by random traffic, against a queue-based reference.
// Revision : 1.0 - initial release
// ============================================================================
module tb_instr_decode_stage;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] instr;
  logic [31:0] in_pc;
  logic        out_valid;
  logic        out_ready;
  logic        rt_type, addi, andi, lw, sw, j, jal, jr, beq, bne;
  logic [4:0]  rs, rt, rd;
  logic [15:0] imm;
  logic [25:0] target;
  logic [31:0] out_pc;
  logic        illegal;
`ifdef ILLEGAL_TRAP_EN
  logic [7:0]  illegal_cnt;
  localparam bit TRAP = 1'b1;
`else
  localparam bit TRAP = 1'b0;
`endif

  always #5 clk = ~clk;

  instr_decode_stage #(.PC_W(32)) dut (
    .clk (clk), .rst_n (rst_n), .flush (flush),
    .in_valid (in_valid), .in_ready (in_ready),
    .instr (instr), .in_pc (in_pc),
    .out_valid (out_valid), .out_ready (out_ready),
    .rt_type (rt_type), .addi (addi), .andi (andi), .lw (lw), .sw (sw),
    .j (j), .jal (jal), .jr (jr), .beq (beq), .bne (bne),
    .rs (rs), .rt (rt), .rd (rd), .imm (imm), .target (target),
    .out_pc (out_pc), .illegal (illegal)
`ifdef ILLEGAL_TRAP_EN
    , .illegal_cnt (illegal_cnt)
`endif
  );

  logic [9:0] obs_flags;
  assign obs_flags = {rt_type, addi, andi, lw, sw, j, jal, jr, beq, bne};

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [31:0] instr;
    logic [31:0] pc;
  } item_t;

  item_t q[$];      // entries the stage currently holds, oldest first
  int    exp_cnt = 0;

  // Expected flags {rt_type,addi,andi,lw,sw,j,jal,jr,beq,bne}; 0 means illegal
  function automatic logic [9:0] ref_flags(input logic [31:0] ins);
    case (ins[31:26])
      6'd0:    return (ins[5:0] == 6'd8) ? 10'b00000_00100 : 10'b10000_00000;
      6'd8:    return 10'b01000_00000;
      6'd12:   return 10'b00100_00000;
      6'd35:   return 10'b00010_00000;
      6'd43:   return 10'b00001_00000;
      6'd2:    return 10'b00000_10000;
      6'd3:    return 10'b00000_01000;
      6'd4:    return 10'b00000_00010;
      6'd5:    return 10'b00000_00001;
      default: return 10'b00000_00000;
    endcase
  endfunction

  function automatic logic [31:0] rand_instr();
    logic [5:0]  ops [0:8];
    logic [31:0] w;
    int          sel;
    ops = '{6'd0, 6'd8, 6'd12, 6'd35, 6'd43, 6'd2, 6'd3, 6'd4, 6'd5};
    w   = $urandom;
    sel = $urandom_range(0, 11);
    if (sel < 9) begin
      w[31:26] = ops[sel];
    end else if (sel == 9) begin
      w[31:26] = 6'd0;
      w[5:0]   = 6'd8;
    end
    return w;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One clock cycle: drive inputs, check outputs against the model, advance the model
  task automatic step(input logic v, input logic [31:0] ins, input logic [31:0] pc,
                      input logic ordy, input logic fl);
    logic exp_ready;
    logic take;
    logic accept;
    in_valid  = v;
    instr     = ins;
    in_pc     = pc;
    out_ready = ordy;
    flush     = fl;
    #2;
    exp_ready = (q.size() < 2) && !fl;
    chk("in_ready", {31'd0, in_ready}, {31'd0, exp_ready});
    chk("out_valid", {31'd0, out_valid}, (q.size() > 0) ? 32'd1 : 32'd0);
    if (q.size() > 0) begin
      chk("flags",   {22'd0, obs_flags}, {22'd0, ref_flags(q[0].instr)});
      chk("rs",      {27'd0, rs},        {27'd0, q[0].instr[25:21]});
      chk("rt",      {27'd0, rt},        {27'd0, q[0].instr[20:16]});
      chk("rd",      {27'd0, rd},        {27'd0, q[0].instr[15:11]});
      chk("imm",     {16'd0, imm},       {16'd0, q[0].instr[15:0]});
      chk("target",  {6'd0, target},     {6'd0, q[0].instr[25:0]});
      chk("out_pc",  out_pc,             q[0].pc);
      chk("illegal", {31'd0, illegal},   (ref_flags(q[0].instr) == 10'd0) ? 32'd1 : 32'd0);
    end else begin
      chk("idle_flags",   {22'd0, obs_flags}, 32'd0);
      chk("idle_illegal", {31'd0, illegal},   32'd0);
    end
`ifdef ILLEGAL_TRAP_EN
    chk("illegal_cnt", {24'd0, illegal_cnt}, exp_cnt);
`endif
    take   = (q.size() > 0) && ordy;
    accept = v && exp_ready;
    if (take) begin
      if (ref_flags(q[0].instr) == 10'd0 && exp_cnt < 255) exp_cnt++;
      void'(q.pop_front());
    end
    if (fl) begin
      q.delete();
    end else if (accept && (TRAP || ref_flags(ins) != 10'd0)) begin
      q.push_back('{ins, pc});
    end
    @(posedge clk);
    #1;
  endtask

  // Reset asserted away from any clock edge; outputs must clear at once
  task automatic async_reset();
    flush = 1'b0;
    #1;
    rst_n = 1'b0;
    #1;
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_flags",     {22'd0, obs_flags}, 32'd0);
    chk("rst_out_pc",    out_pc,             32'd0);
    q.delete();
    exp_cnt = 0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n     = 1'b0;
    flush     = 1'b0;
    in_valid  = 1'b0;
    instr     = '0;
    in_pc     = '0;
    out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Reset state
    step(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);

    // addi $8,$8,5 with one-cycle latency
    step(1'b1, 32'h2108_0005, 32'h0000_0104, 1'b1, 1'b0);
    chk("addi_flags", {22'd0, obs_flags}, 32'h100);
    chk("addi_rs",    {27'd0, rs},        32'd8);
    chk("addi_rt",    {27'd0, rt},        32'd8);
    chk("addi_imm",   {16'd0, imm},       32'h0005);
    step(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);

    // jr then add, back-to-back
    step(1'b1, 32'h0000_0008, 32'h0000_0200, 1'b1, 1'b0);
    chk("jr_flags", {22'd0, obs_flags}, 32'h004);
    step(1'b1, 32'h0109_5020, 32'h0000_0204, 1'b1, 1'b0);
    chk("add_flags", {22'd0, obs_flags}, 32'h200);
    chk("add_rd",    {27'd0, rd},        32'd10);
    step(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);

    // Stall: three offers, only two held, then drain in order
    step(1'b1, 32'h8C22_0010, 32'h0000_0300, 1'b0, 1'b0);
    step(1'b1, 32'hAC43_0020, 32'h0000_0304, 1'b0, 1'b0);
    chk("full_in_ready", {31'd0, in_ready}, 32'd0);
    step(1'b1, 32'h1064_0003, 32'h0000_0308, 1'b0, 1'b0);
    step(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
    step(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
    step(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);

    // Flush while FULL
    step(1'b1, 32'h0800_0040, 32'h0000_0400, 1'b0, 1'b0);
    step(1'b1, 32'h0C00_0080, 32'h0000_0404, 1'b0, 1'b0);
    step(1'b1, 32'h1485_0001, 32'h0000_0408, 1'b0, 1'b1);
    flush = 1'b0;
    #1;
    chk("flush_out_valid", {31'd0, out_valid}, 32'd0);
    chk("flush_flags",     {22'd0, obs_flags}, 32'd0);
    chk("flush_in_ready",  {31'd0, in_ready},  32'd1);
    step(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
    step(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);

    // Illegal opcode, then a long run to saturate the trap counter
    step(1'b1, 32'hFC00_0000, 32'h0000_0500, 1'b1, 1'b0);
    step(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
    for (int i = 0; i < 300; i++) begin
      step(1'b1, 32'hFC00_0000, 32'h0000_0600 + i, 1'b1, 1'b0);
    end
    step(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
    step(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);

    // Reset in the middle of a FULL stall, then resume
    step(1'b1, 32'h3128_00FF, 32'h0000_0700, 1'b0, 1'b0);
    step(1'b1, 32'h2108_0001, 32'h0000_0704, 1'b0, 1'b0);
    async_reset();
    step(1'b1, 32'h2108_0007, 32'h0000_0800, 1'b1, 1'b0);
    step(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);

    // Random traffic with back-pressure and occasional flush
    for (int i = 0; i < 1500; i++) begin
      step($urandom_range(0, 3) != 0, rand_instr(), $urandom,
           $urandom_range(0, 3) != 0, $urandom_range(0, 19) == 0);
    end
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
